// File: rtl/mont_exp_ctrl_if.sv
// Bundle of the host request/response and Montgomery multiplier signals used by
// mont_exp_ctrl; the controller attaches to the slave modport.
interface mont_exp_ctrl_if #(
    parameter int unsigned WIDTH     = 1024,
    parameter int unsigned EXP_WIDTH = 1024,
    parameter int unsigned LEN_W     = $clog2(EXP_WIDTH + 1)
);
    // Host side
    logic                 start;
    logic [WIDTH-1:0]     in_x;
    logic [EXP_WIDTH-1:0] in_e;
    logic [LEN_W-1:0]     e_len;
    logic [WIDTH-1:0]     in_m;
    logic [WIDTH-1:0]     in_r;
    logic [WIDTH-1:0]     in_r2;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     result;

    // Multiplier side
    logic                 mul_start;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic [WIDTH-1:0]     mul_m;
    logic [WIDTH-1:0]     mul_result;
    logic                 mul_done;

    modport slave (
        input  start, in_x, in_e, e_len, in_m, in_r, in_r2, mul_result, mul_done,
        output busy, done, result, mul_start, mul_a, mul_b, mul_m
    );

    modport master (
        output start, in_x, in_e, e_len, in_m, in_r, in_r2, mul_result, mul_done,
        input  busy, done, result, mul_start, mul_a, mul_b, mul_m
    );
endinterface

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for x^e mod M around one shared
// Montgomery multiplier (a*b*R^-1 mod M); all outputs are registered.
module mont_exp_ctrl #(
    parameter int unsigned WIDTH     = 1024,
    parameter int unsigned EXP_WIDTH = 1024,
    parameter int unsigned LEN_W     = $clog2(EXP_WIDTH + 1)
) (
    input logic            clk,
    input logic            reset,
    mont_exp_ctrl_if.slave bus_io
);

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StSq,
        StMul,
        StFin,
        StDone
    } state_e;

    localparam logic [LEN_W-1:0] LenMax = LEN_W'(EXP_WIDTH);
    localparam logic [LEN_W-1:0] IdxOne = LEN_W'(1);
    localparam logic [WIDTH-1:0] OneW   = WIDTH'(1);

    state_e               state_q;
    logic                 issued_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 mul_start_q;
    logic [WIDTH-1:0]     result_q;
    logic [WIDTH-1:0]     mul_a_q;
    logic [WIDTH-1:0]     mul_b_q;
    logic [WIDTH-1:0]     mul_m_q;
    logic [WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]     xt_q;
    logic [EXP_WIDTH-1:0] e_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     idx_q;

    logic [LEN_W-1:0]     len_clip;
    logic [EXP_WIDTH-1:0] e_shift;
    logic                 e_bit;
    logic                 idx_zero;
    logic                 op_done;

    always_comb begin
        len_clip = (bus_io.e_len > LenMax) ? LenMax : bus_io.e_len;
        // Shift instead of indexing so idx_q may be wider than the bit-select range
        e_shift  = e_q >> idx_q;
        e_bit    = e_shift[0];
        idx_zero = (idx_q == '0);
        // Completion only counts once the operation has actually been issued
        op_done  = issued_q & bus_io.mul_done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            issued_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mul_start_q <= 1'b0;
            result_q    <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_m_q     <= '0;
            acc_q       <= '0;
            xt_q        <= '0;
            e_q         <= '0;
            len_q       <= '0;
            idx_q       <= '0;
        end else begin
            mul_start_q <= 1'b0;
            done_q      <= 1'b0;

            if ((state_q == StConv || state_q == StSq || state_q == StMul ||
                 state_q == StFin) && !issued_q) begin
                issued_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus_io.start) begin
                        busy_q      <= 1'b1;
                        e_q         <= bus_io.in_e;
                        len_q       <= len_clip;
                        idx_q       <= len_clip - IdxOne;
                        acc_q       <= bus_io.in_r;
                        mul_m_q     <= bus_io.in_m;
                        state_q     <= StConv;
                        mul_start_q <= 1'b1;
                        issued_q    <= 1'b0;
                        mul_a_q     <= bus_io.in_x;
                        mul_b_q     <= bus_io.in_r2;
                    end
                end

                StConv: begin
                    if (op_done) begin
                        xt_q        <= bus_io.mul_result;
                        mul_start_q <= 1'b1;
                        issued_q    <= 1'b0;
                        mul_a_q     <= acc_q;
                        if (len_q == '0) begin
                            state_q <= StFin;
                            mul_b_q <= OneW;
                        end else begin
                            state_q <= StSq;
                            mul_b_q <= acc_q;
                        end
                    end
                end

                StSq: begin
                    if (op_done) begin
                        acc_q       <= bus_io.mul_result;
                        mul_start_q <= 1'b1;
                        issued_q    <= 1'b0;
                        mul_a_q     <= bus_io.mul_result;
                        if (e_bit) begin
                            state_q <= StMul;
                            mul_b_q <= xt_q;
                        end else if (idx_zero) begin
                            state_q <= StFin;
                            mul_b_q <= OneW;
                        end else begin
                            idx_q   <= idx_q - IdxOne;
                            state_q <= StSq;
                            mul_b_q <= bus_io.mul_result;
                        end
                    end
                end

                StMul: begin
                    if (op_done) begin
                        acc_q       <= bus_io.mul_result;
                        mul_start_q <= 1'b1;
                        issued_q    <= 1'b0;
                        mul_a_q     <= bus_io.mul_result;
                        if (idx_zero) begin
                            state_q <= StFin;
                            mul_b_q <= OneW;
                        end else begin
                            idx_q   <= idx_q - IdxOne;
                            state_q <= StSq;
                            mul_b_q <= bus_io.mul_result;
                        end
                    end
                end

                StFin: begin
                    if (op_done) begin
                        result_q <= bus_io.mul_result;
                        done_q   <= 1'b1;
                        issued_q <= 1'b0;
                        state_q  <= StDone;
                    end
                end

                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus_io.busy      = busy_q;
    assign bus_io.done      = done_q;
    assign bus_io.result    = result_q;
    assign bus_io.mul_start = mul_start_q;
    assign bus_io.mul_a     = mul_a_q;
    assign bus_io.mul_b     = mul_b_q;
    assign bus_io.mul_m     = mul_m_q;

endmodule
